lcd_capture: RTL

- Sink for the PPU display stream (pixel strobe, 2-bit color, hsync, vsync).
- Maps each color index through the BGP palette to a 2-bit shade.
- Tracks screen x/y and writes {address, shade} to a framebuffer write port through a small FIFO with valid/ready backpressure.
- Flags malformed lines or frames and FIFO overflow; feeds the scan-out/video side of the design.

---
 rtl/lcd_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_capture.sv
// LCD stream capture: palette-maps PPU pixels into a small FIFO feeding a framebuffer write port.
// Optional LCD_CAPTURE_STATS_EN adds frame_count / err_count statistics outputs.
module lcd_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int LINE_W     = 160,
  parameter int LINE_H     = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bgp,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  output logic [14:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        overflow,
  input  logic        err_clr
`ifdef LCD_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
`endif
);

  localparam int XW = $clog2(LINE_W + 1);
  localparam int YW = $clog2(LINE_H + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XW-1:0] X_END = XW'(LINE_W);
  localparam logic [YW-1:0] Y_END = YW'(LINE_H);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {SYNC, ACTIVE, HBLANK, VBLANK} state_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  shade;
  } ent_t;

  state_t        state, state_nx;
  logic          hs_q, vs_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [14:0]   line_base;

  logic hs_rise, hs_fall, vs_rise, vs_fall, accept;
  logic push, err_set, line_next, frame_rst, x_inc, fs_nx, fd_nx;

  assign hs_rise = lcd_hsync & ~hs_q;
  assign hs_fall = ~lcd_hsync & hs_q;
  assign vs_rise = lcd_vsync & ~vs_q;
  assign vs_fall = ~lcd_vsync & vs_q;
  assign accept  = lcd_pixel & ~lcd_hsync & ~lcd_vsync;

  // vsync rise outranks hsync rise; pixels only count inside ACTIVE
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    err_set   = 1'b0;
    line_next = 1'b0;
    frame_rst = 1'b0;
    x_inc     = 1'b0;
    fs_nx     = 1'b0;
    fd_nx     = 1'b0;
    case (state)
      SYNC, VBLANK: begin
        if (vs_fall) begin
          state_nx  = ACTIVE;
          frame_rst = 1'b1;
          fs_nx     = 1'b1;
        end
      end
      ACTIVE, HBLANK: begin
        if (vs_rise) begin
          if (y != Y_END) err_set = 1'b1;
          fd_nx    = 1'b1;
          state_nx = VBLANK;
        end else if (state == ACTIVE) begin
          if (hs_rise) begin
            if (x != X_END) err_set = 1'b1;
            line_next = 1'b1;
            state_nx  = HBLANK;
          end else if (accept) begin
            if (x < X_END) begin
              x_inc = 1'b1;
              if (y < Y_END) push = 1'b1;
              else           err_set = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end else if (hs_fall) begin
          state_nx = ACTIVE;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // FIFO
  ent_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok, ovf_set;
  ent_t          wr_ent;

  assign full     = (count == C_FULL);
  assign fb_valid = (count != '0);
  assign pop      = fb_valid & fb_ready;
  assign push_ok  = push & (~full | pop);
  assign ovf_set  = push & full & ~pop;

  assign wr_ent.addr  = line_base + 15'(x);
  assign wr_ent.shade = bgp[{lcd_color, 1'b0} +: 2];

  assign fb_addr = fb_valid ? mem[rd_ptr].addr  : '0;
  assign fb_data = fb_valid ? mem[rd_ptr].shade : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      hs_q        <= lcd_hsync;
      vs_q        <= lcd_vsync;
      frame_start <= fs_nx;
      frame_done  <= fd_nx;
      line_err    <= err_set | (line_err & ~err_clr);
      overflow    <= ovf_set | (overflow & ~err_clr);
      if (frame_rst) begin
        x         <= '0;
        y         <= '0;
        line_base <= '0;
      end else if (line_next) begin
        x <= '0;
        // saturate at LINE_H so the address never runs past the frame
        if (y < Y_END) begin
          y         <= y + YW'(1);
          line_base <= line_base + 15'(LINE_W);
        end
      end else if (x_inc) begin
        x <= x + XW'(1);
      end
    end
  end

`ifdef LCD_CAPTURE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (fd_nx) frame_count <= frame_count + 16'd1;
      if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
